// File: rtl/rx_link_fault_monitor_pkg.sv
// Shared definitions for the receive-side link-fault monitor: fault codes,
// XGMII character constants and the fault state machine context.
package rx_link_fault_monitor_pkg;

    localparam logic [1:0]  LF_OK     = 2'b00;
    localparam logic [1:0]  LF_LOCAL  = 2'b10;
    localparam logic [1:0]  LF_REMOTE = 2'b11;

    localparam logic [7:0]  SEQ_CHAR  = 8'h9C;
    localparam logic [7:0]  IDLE_CHAR = 8'h07;
    localparam logic [31:0] IDLE_COL  = {4{IDLE_CHAR}};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FAULT = 2'd2
    } lf_state_e;

    typedef struct packed {
        lf_state_e  state;
        logic [2:0] seq_cnt;
        logic [7:0] col_cnt;
        logic [1:0] last_type;
        logic [1:0] link_fault;
    } lf_ctx_t;

    localparam lf_ctx_t LF_CTX_RESET = '{
        state:      ST_INIT,
        seq_cnt:    3'd0,
        col_cnt:    8'd0,
        last_type:  LF_OK,
        link_fault: LF_OK
    };

endpackage

// File: rtl/rx_link_fault_monitor_column_decode.sv
// Recognises a single XGMII column carrying a local or remote fault
// sequence ordered set.
module rx_lf_column_decode
    import rx_link_fault_monitor_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic [3:0]  flags_i,
    output logic        is_seq_o,
    output logic [1:0]  seq_type_o
);

    logic frame_ok;
    logic lane3_local;
    logic lane3_remote;

    assign frame_ok     = (flags_i == 4'b0001) && (col_i[7:0] == SEQ_CHAR) &&
                          (col_i[15:8] == 8'h00) && (col_i[23:16] == 8'h00);
    assign lane3_local  = (col_i[31:24] == 8'h01);
    assign lane3_remote = (col_i[31:24] == 8'h02);

    assign is_seq_o   = frame_ok && (lane3_local || lane3_remote);
    assign seq_type_o = lane3_remote ? LF_REMOTE : LF_LOCAL;

endmodule

// File: rtl/rx_link_fault_monitor.sv
// Reconciliation-sublayer receive link-fault monitor: counts fault sequence
// ordered sets per column, drives link_fault and forwards data one cycle late.
module rx_link_fault_monitor
    import rx_link_fault_monitor_pkg::*;
#(
    parameter int COL_WINDOW    = 128,
    parameter int SEQ_THRESHOLD = 4
) (
    input  logic        rxclk,
    input  logic        reset_n,
    input  logic [63:0] rxd_in,
    input  logic [7:0]  rxc_in,
    output logic [63:0] rxd_out,
    output logic [7:0]  rxc_out,
    output logic [1:0]  link_fault,
    output logic        seq_seen
);

    localparam logic [7:0] WIN = COL_WINDOW[7:0];
    localparam logic [2:0] THR = SEQ_THRESHOLD[2:0];

    logic [1:0] col_is_seq;
    logic [1:0] col_type [2];
    logic [63:0] rxd_d, rxd_q;
    logic [7:0]  rxc_d, rxc_q;
    logic        seq_seen_d, seq_seen_q;
    lf_ctx_t     ctx_mid, ctx_d, ctx_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_col
            rx_lf_column_decode u_dec (
                .col_i      (rxd_in[gi*32 +: 32]),
                .flags_i    (rxc_in[gi*4 +: 4]),
                .is_seq_o   (col_is_seq[gi]),
                .seq_type_o (col_type[gi])
            );
            assign rxd_d[gi*32 +: 32] = col_is_seq[gi] ? IDLE_COL : rxd_in[gi*32 +: 32];
            assign rxc_d[gi*4 +: 4]   = col_is_seq[gi] ? 4'hF : rxc_in[gi*4 +: 4];
        end
    endgenerate

    // One column's effect on the fault context; applied twice per cycle.
    function automatic lf_ctx_t col_step(input lf_ctx_t c, input logic is_seq,
                                         input logic [1:0] t);
        lf_ctx_t n;
        n = c;
        if (is_seq) begin
            n.col_cnt = 8'd0;
            if ((c.state != ST_INIT) && (t == c.last_type)) begin
                if (c.seq_cnt < THR) begin
                    n.seq_cnt = c.seq_cnt + 3'd1;
                end
            end else begin
                n.seq_cnt   = 3'd1;
                n.last_type = t;
            end
            if (n.seq_cnt == THR) begin
                n.link_fault = t;
                n.state      = ST_FAULT;
            end else if (c.state == ST_INIT) begin
                n.state = ST_COUNT;
            end
        end else if (c.state != ST_INIT) begin
            if (c.col_cnt < WIN) begin
                n.col_cnt = c.col_cnt + 8'd1;
            end
            if (n.col_cnt == WIN) begin
                n.seq_cnt    = 3'd0;
                n.col_cnt    = 8'd0;
                n.link_fault = LF_OK;
                n.state      = ST_INIT;
            end
        end
        return n;
    endfunction

    always_comb begin
        ctx_mid    = col_step(ctx_q, col_is_seq[0], col_type[0]);
        ctx_d      = col_step(ctx_mid, col_is_seq[1], col_type[1]);
        seq_seen_d = |col_is_seq;
    end

    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            ctx_q      <= LF_CTX_RESET;
            rxd_q      <= {2{IDLE_COL}};
            rxc_q      <= 8'hFF;
            seq_seen_q <= 1'b0;
        end else begin
            ctx_q      <= ctx_d;
            rxd_q      <= rxd_d;
            rxc_q      <= rxc_d;
            seq_seen_q <= seq_seen_d;
        end
    end

    assign rxd_out    = rxd_q;
    assign rxc_out    = rxc_q;
    assign link_fault = ctx_q.link_fault;
    assign seq_seen   = seq_seen_q;

endmodule

// File: tb/tb_rx_link_fault_monitor.sv
// Directed bench for the receive link-fault monitor: fault detection,
// window expiry, type changes, reset and data pass-through.
module tb_rx_link_fault_monitor;

    localparam logic [31:0] IC = 32'h07070707;
    localparam logic [31:0] LC = 32'h0100009C;
    localparam logic [31:0] RC = 32'h0200009C;
    localparam logic [3:0]  FI = 4'hF;
    localparam logic [3:0]  FS = 4'h1;

    logic        rxclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] rxd_in = {IC, IC};
    logic [7:0]  rxc_in = 8'hFF;
    logic [63:0] rxd_out;
    logic [7:0]  rxc_out;
    logic [1:0]  link_fault;
    logic        seq_seen;

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;

    rx_link_fault_monitor dut (
        .rxclk      (rxclk),
        .reset_n    (reset_n),
        .rxd_in     (rxd_in),
        .rxc_in     (rxc_in),
        .rxd_out    (rxd_out),
        .rxc_out    (rxc_out),
        .link_fault (link_fault),
        .seq_seen   (seq_seen)
    );

    always #5 rxclk = ~rxclk;

    task automatic cyc(input logic [31:0] c0, input logic [3:0] f0,
                       input logic [31:0] c1, input logic [3:0] f1);
        rxd_in = {c1, c0};
        rxc_in = {f1, f0};
        @(posedge rxclk);
        #1;
        cyc_no++;
        $display("cyc %0d rst_n=%b rxd_in=%h rxc_in=%h -> rxd_out=%h rxc_out=%h lf=%b seen=%b",
                 cyc_no, reset_n, rxd_in, rxc_in, rxd_out, rxc_out, link_fault, seq_seen);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(IC, FI, IC, FI);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(IC, FI, IC, FI);
        reset_n = 1'b1;
    endtask

    // Reference column transform following the ordered-set definition.
    function automatic logic col_is_seq(input logic [31:0] c, input logic [3:0] f);
        return (f == 4'b0001) && (c[7:0] == 8'h9C) && (c[23:8] == 16'h0000) &&
               ((c[31:24] == 8'h01) || (c[31:24] == 8'h02));
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        cyc(LC, FS, RC, FS);
        checks++;
        if (rxd_out !== {IC, IC} || rxc_out !== 8'hFF) begin
            failures++;
            $display("FAIL reset_data got=%h/%h exp=%h/ff", rxd_out, rxc_out, {IC, IC});
        end
        checks++;
        if (link_fault !== 2'b00 || seq_seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got lf=%b seen=%b exp lf=00 seen=0", link_fault, seq_seen);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_local_fault();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(LC, FS, IC, FI);
            checks++;
            if (link_fault !== ((i < 3) ? 2'b00 : 2'b10)) begin
                failures++;
                $display("FAIL local_seq%0d got=%b exp=%b", i, link_fault, (i < 3) ? 2'b00 : 2'b10);
            end
            checks++;
            if (seq_seen !== 1'b1 || rxd_out !== {IC, IC} || rxc_out !== 8'hFF) begin
                failures++;
                $display("FAIL local_out%0d got seen=%b rxd=%h rxc=%h exp seen=1 rxd=%h rxc=ff",
                         i, seq_seen, rxd_out, rxc_out, {IC, IC});
            end
            cyc(IC, FI, IC, FI);
            checks++;
            if (link_fault !== ((i < 3) ? 2'b00 : 2'b10) || seq_seen !== 1'b0) begin
                failures++;
                $display("FAIL local_idle%0d got lf=%b seen=%b exp lf=%b seen=0",
                         i, link_fault, seq_seen, (i < 3) ? 2'b00 : 2'b10);
            end
        end
    endtask

    task automatic test_remote_both_cols();
        do_reset();
        cyc(RC, FS, RC, FS);
        checks++;
        if (link_fault !== 2'b00 || seq_seen !== 1'b1) begin
            failures++;
            $display("FAIL remote_first got lf=%b seen=%b exp lf=00 seen=1", link_fault, seq_seen);
        end
        cyc(RC, FS, RC, FS);
        checks++;
        if (link_fault !== 2'b11 || rxd_out !== {IC, IC} || rxc_out !== 8'hFF) begin
            failures++;
            $display("FAIL remote_second got lf=%b rxd=%h rxc=%h exp lf=11 rxd=%h rxc=ff",
                     link_fault, rxd_out, rxc_out, {IC, IC});
        end
    endtask

    task automatic test_window();
        do_reset();
        cyc(LC, FS, LC, FS);
        cyc(LC, FS, LC, FS);
        checks++;
        if (link_fault !== 2'b10) begin
            failures++;
            $display("FAIL win_setup got=%b exp=10", link_fault);
        end
        cyc(LC, FS, LC, FS);
        idle_cycles(63);
        cyc(IC, FI, LC, FS);
        checks++;
        if (link_fault !== 2'b10) begin
            failures++;
            $display("FAIL win_127_then_seq got=%b exp=10", link_fault);
        end
        idle_cycles(63);
        checks++;
        if (link_fault !== 2'b10) begin
            failures++;
            $display("FAIL win_126_cols got=%b exp=10", link_fault);
        end
        idle_cycles(1);
        checks++;
        if (link_fault !== 2'b00) begin
            failures++;
            $display("FAIL win_128_cols got=%b exp=00", link_fault);
        end
        // Expiry on column 0 followed by a sequence on column 1 in the same cycle.
        cyc(LC, FS, LC, FS);
        cyc(LC, FS, LC, FS);
        cyc(LC, FS, IC, FI);
        idle_cycles(63);
        checks++;
        if (link_fault !== 2'b10) begin
            failures++;
            $display("FAIL win_127_hold got=%b exp=10", link_fault);
        end
        cyc(IC, FI, RC, FS);
        checks++;
        if (link_fault !== 2'b00 || seq_seen !== 1'b1) begin
            failures++;
            $display("FAIL win_expire_col0 got lf=%b seen=%b exp lf=00 seen=1", link_fault, seq_seen);
        end
        cyc(RC, FS, RC, FS);
        checks++;
        if (link_fault !== 2'b00) begin
            failures++;
            $display("FAIL win_recount3 got=%b exp=00", link_fault);
        end
        cyc(RC, FS, IC, FI);
        checks++;
        if (link_fault !== 2'b11) begin
            failures++;
            $display("FAIL win_recount4 got=%b exp=11", link_fault);
        end
    endtask

    task automatic test_type_change();
        do_reset();
        cyc(LC, FS, LC, FS);
        cyc(LC, FS, LC, FS);
        for (int i = 0; i < 4; i++) begin
            cyc(RC, FS, IC, FI);
            checks++;
            if (link_fault !== ((i < 3) ? 2'b10 : 2'b11)) begin
                failures++;
                $display("FAIL fault_switch%0d got=%b exp=%b", i, link_fault, (i < 3) ? 2'b10 : 2'b11);
            end
        end
        do_reset();
        cyc(LC, FS, RC, FS);
        cyc(RC, FS, IC, FI);
        checks++;
        if (link_fault !== 2'b00) begin
            failures++;
            $display("FAIL col_type_ab_cnt2 got=%b exp=00", link_fault);
        end
        cyc(RC, FS, RC, FS);
        checks++;
        if (link_fault !== 2'b11) begin
            failures++;
            $display("FAIL col_type_ab_cnt4 got=%b exp=11", link_fault);
        end
    endtask

    task automatic test_invalid_seq();
        logic [31:0] bad_col [3];
        logic [3:0]  bad_flg [3];
        bad_col[0] = 32'h0300009C; bad_flg[0] = FS;
        bad_col[1] = 32'h0100119C; bad_flg[1] = FS;
        bad_col[2] = LC;           bad_flg[2] = 4'b0011;
        do_reset();
        cyc(LC, FS, IC, FI);
        for (int i = 0; i < 3; i++) begin
            cyc(bad_col[i], bad_flg[i], IC, FI);
            checks++;
            if (seq_seen !== 1'b0 || rxd_out !== {IC, bad_col[i]} || rxc_out !== {FI, bad_flg[i]}) begin
                failures++;
                $display("FAIL invalid%0d got seen=%b rxd=%h rxc=%h exp seen=0 rxd=%h rxc=%h",
                         i, seq_seen, rxd_out, rxc_out, {IC, bad_col[i]}, {FI, bad_flg[i]});
            end
        end
        cyc(LC, FS, IC, FI);
        cyc(LC, FS, IC, FI);
        checks++;
        if (link_fault !== 2'b00) begin
            failures++;
            $display("FAIL invalid_cnt3 got=%b exp=00", link_fault);
        end
        cyc(LC, FS, IC, FI);
        checks++;
        if (link_fault !== 2'b10) begin
            failures++;
            $display("FAIL invalid_cnt4 got=%b exp=10", link_fault);
        end
    endtask

    task automatic test_reset_mid_fault();
        reset_n = 1'b0;
        cyc(LC, FS, LC, FS);
        checks++;
        if (link_fault !== 2'b00 || seq_seen !== 1'b0 || rxd_out !== {IC, IC} || rxc_out !== 8'hFF) begin
            failures++;
            $display("FAIL reset_mid_fault got lf=%b seen=%b rxd=%h rxc=%h exp lf=00 seen=0 rxd=%h rxc=ff",
                     link_fault, seq_seen, rxd_out, rxc_out, {IC, IC});
        end
        reset_n = 1'b1;
        cyc(LC, FS, LC, FS);
        checks++;
        if (link_fault !== 2'b00 || seq_seen !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_cnt2 got lf=%b seen=%b exp lf=00 seen=1", link_fault, seq_seen);
        end
        cyc(LC, FS, IC, FI);
        checks++;
        if (link_fault !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_cnt3 got=%b exp=00", link_fault);
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] c [2];
        logic [3:0]  f [2];
        logic [63:0] exp_d;
        logic [7:0]  exp_c;
        logic        exp_s;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            exp_s = 1'b0;
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 3))
                    0: begin c[k] = LC; f[k] = FS; end
                    1: begin c[k] = RC; f[k] = FS; end
                    default: begin c[k] = $urandom; f[k] = 4'($urandom_range(0, 15)); end
                endcase
                if (col_is_seq(c[k], f[k])) begin
                    exp_d[k*32 +: 32] = IC;
                    exp_c[k*4 +: 4]   = FI;
                    exp_s             = 1'b1;
                end else begin
                    exp_d[k*32 +: 32] = c[k];
                    exp_c[k*4 +: 4]   = f[k];
                end
            end
            cyc(c[0], f[0], c[1], f[1]);
            checks++;
            if (rxd_out !== exp_d || rxc_out !== exp_c || seq_seen !== exp_s) begin
                failures++;
                $display("FAIL passthru%0d got rxd=%h rxc=%h seen=%b exp rxd=%h rxc=%h seen=%b",
                         n, rxd_out, rxc_out, seq_seen, exp_d, exp_c, exp_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_local_fault();
        test_remote_both_cols();
        test_window();
        test_type_change();
        test_invalid_seq();
        test_reset_mid_fault();
        test_passthrough();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
